fc_infer_ctrl: RTL
==================

Name: fc_infer_ctrl

Overview:
- Sequencer for the GRU FP output layer, the 2x4 weighted-sum engine producing out1/out2/result_valid.
- Holds the 8 output-layer weights in a config register file.
- Accepts hidden-state vectors over a valid/ready handshake and issues one engine evaluation per vector.
- Waits for the engine result with a timeout, computes class/margin, and queues results in a small FIFO for downstream consumers.

Parameters:
- DEPTH, 4, result FIFO entries (power of 2, >=2).
- TIMEOUT, 64, max cycles in WAIT before abort (>=2).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- h_valid  in  1  hidden vector offered.
- h_ready  out  1  controller accepts vector this cycle.
- h_data  in  64  {h4,h3,h2,h1}, h1 at [15:0], signed Q2.14.
- cfg_we  in  1  weight write strobe.
- cfg_addr  in  3  0..3 = w11..w14, 4..7 = w21..w24.
- cfg_wdata  in  16  weight value, signed Q2.14.
- eng_en  out  1  one-cycle start pulse to engine.
- eng_w  out  128  {w24..w21,w14..w11}, w11 at [15:0].
- eng_h  out  64  latched hidden vector.
- eng_valid  in  1  engine result_valid.
- eng_out1  in  16  class-1 score, signed Q2.14.
- eng_out2  in  16  class-2 score, signed Q2.14.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer pops head.
- res_pred  out  1  head class (1 = out1 wins).
- res_margin  out  16  head saturated out1-out2.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky timeout flag.
- cfg_err  out  1  sticky illegal-config flag.
- err_clr  in  1  clears both sticky flags.
- sample_cnt  out  16  completed samples, wraps at 0xFFFF->0.

Behaviour:
- Reset (async, rst_n=0) clears:
  - state to IDLE; all weights, eng_h and FIFO pointers/count to 0.
  - Outputs: eng_en=0, res_valid=0, res_pred=0, res_margin=0, h_ready=0, busy=0, timeout_err=0, cfg_err=0, sample_cnt=0.
- Reset mid-operation (any state) aborts the in-flight sample and empties the FIFO; a later eng_valid is ignored while in IDLE.
- h_ready = (state==IDLE) && (fifo_count < DEPTH), registered-free combinational.
  - Full-FIFO back-pressure is handled here, so PUSH never blocks.
- FSM:
  - IDLE: on h_valid&&h_ready, latch h_data into eng_h, go ISSUE.
  - ISSUE: eng_en=1 for exactly this cycle, clear timeout counter, go WAIT.
  - WAIT: if eng_valid, register eng_out1/eng_out2, go PUSH. Else increment counter; when counter reaches TIMEOUT-1 with no eng_valid, set timeout_err, drop the sample, go IDLE.
  - PUSH: write {pred,margin} to FIFO, sample_cnt+1, go IDLE.
- eng_h and eng_w are stable from ISSUE through WAIT exit.
- eng_valid outside WAIT is ignored.
- Latency: accept at cycle 0, eng_en at cycle 1. With eng_valid at cycle k, res_valid (if FIFO was empty) rises at cycle k+2. Next accept is possible at cycle k+2.
- Arithmetic:
  - diff = sign-extended 17-bit out1 - out2.
  - margin = diff saturated to [0x8000, 0x7FFF].
  - pred = (diff > 0), signed. Tie gives pred 0.
- Config:
  - cfg_we accepted only in IDLE.
  - cfg_we while busy: write dropped, cfg_err set.
  - Simultaneous cfg_we and accept in IDLE: write takes effect, and the new weights are used for that sample.
- FIFO:
  - res_* are driven from the head entry.
  - Pop on res_valid&&res_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pop when empty is ignored.
- err_clr clears the flags. The same-cycle set event wins over err_clr.

Test Plan:
- Write w11=0x4000, rest 0; send h1=0x2000; bench engine (latency 3) returns out1=0x2000, out2=0xE000 -> eng_en single pulse, res_margin=0x4000, res_pred=1, sample_cnt=1.
- Engine returns out1=0x7000, out2=0x9000 -> res_margin=0x7FFF, pred=1. Then out1=0x9000, out2=0x7000 -> res_margin=0x8000, pred=0. Then out1=out2=0x1234 -> margin 0, pred 0.
- res_ready=0, offer 5 vectors with DEPTH=4 -> 4 results queued, h_ready held 0. Pop one -> h_ready=1 next cycle, 5th result queued. FIFO order preserved.
- TIMEOUT=16, engine never responds -> timeout_err=1 after 16 WAIT cycles, no FIFO entry, sample_cnt unchanged, h_ready=1. err_clr -> timeout_err=0.
- cfg_we to addr 5 during WAIT -> cfg_err=1, w22 unchanged on eng_w.
- Assert rst_n=0 during WAIT with 2 FIFO entries -> all outputs at reset values immediately. Late eng_valid after release produces no result.

Source files
------------

// File: rtl/fc_infer_ctrl.sv
// fc_infer_ctrl: sequencer for the GRU output-layer 2x4 weighted-sum engine.
// Holds weights, issues one evaluation per hidden vector, queues class/margin.
module fc_infer_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         h_valid,
  output logic         h_ready,
  input  logic [63:0]  h_data,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_addr,
  input  logic [15:0]  cfg_wdata,
  output logic         eng_en,
  output logic [127:0] eng_w,
  output logic [63:0]  eng_h,
  input  logic         eng_valid,
  input  logic [15:0]  eng_out1,
  input  logic [15:0]  eng_out2,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_pred,
  output logic [15:0]  res_margin,
  output logic         busy,
  output logic         timeout_err,
  output logic         cfg_err,
  input  logic         err_clr,
  output logic [15:0]  sample_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PUSH
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_w [8];
  logic [63:0]   r_h;
  logic [TW-1:0] r_tcnt;
  logic [15:0]   r_o1;
  logic [15:0]   r_o2;
  logic          r_fp [DEPTH];
  logic [15:0]   r_fm [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          r_to_err;
  logic          r_cfg_err;
  logic [15:0]   r_scnt;

  logic          w_accept;
  logic          w_tmo;
  logic          w_push;
  logic          w_pop;
  logic          w_pred;
  logic          w_cfg_ok;
  logic          w_cfg_bad;
  logic [16:0]   w_diff;
  logic [15:0]   w_margin;

  assign h_ready   = rst_n && (r_state == S_IDLE)
                     && (r_cnt < (AW+1)'(DEPTH));
  assign w_accept  = h_valid && h_ready;
  assign w_cfg_ok  = cfg_we && (r_state == S_IDLE);
  assign w_cfg_bad = cfg_we && (r_state != S_IDLE);
  assign w_tmo     = (r_state == S_WAIT) && !eng_valid
                     && (r_tcnt == TW'(TIMEOUT - 1));
  assign w_push    = (r_state == S_PUSH);
  assign w_pop     = res_valid && res_ready;

  // 17-bit difference cannot overflow; saturate back into Q2.14
  assign w_diff = {r_o1[15], r_o1} - {r_o2[15], r_o2};
  assign w_pred = ~w_diff[16] & (|w_diff);

  always_comb begin
    w_margin = w_diff[15:0];
    unique case (1'b1)
      (w_diff[16:15] == 2'b01): w_margin = 16'h7FFF;
      (w_diff[16:15] == 2'b10): w_margin = 16'h8000;
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    eng_en = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: begin
        eng_en = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (eng_valid)  w_next = S_PUSH;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_PUSH:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_w[i] <= '0;
      r_h <= '0;
    end else begin
      if (w_cfg_ok) r_w[cfg_addr] <= cfg_wdata;
      if (w_accept) r_h <= h_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_o1   <= '0;
      r_o2   <= '0;
    end else begin
      if (r_state == S_ISSUE) r_tcnt <= '0;
      else if (r_state == S_WAIT && !eng_valid)
        r_tcnt <= r_tcnt + TW'(1);
      if (r_state == S_WAIT && eng_valid) begin
        r_o1 <= eng_out1;
        r_o2 <= eng_out2;
      end
    end
  end

  // h_ready already blocks accepts when full, so a push always has room
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fp[i] <= 1'b0;
        r_fm[i] <= '0;
      end
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fp[r_wp] <= w_pred;
        r_fm[r_wp] <= w_margin;
        r_wp       <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_err  <= 1'b0;
      r_cfg_err <= 1'b0;
      r_scnt    <= '0;
    end else begin
      if (w_tmo)        r_to_err <= 1'b1;
      else if (err_clr) r_to_err <= 1'b0;
      if (w_cfg_bad)    r_cfg_err <= 1'b1;
      else if (err_clr) r_cfg_err <= 1'b0;
      if (w_push) r_scnt <= r_scnt + 16'd1;
    end
  end

  always_comb begin
    eng_w = '0;
    for (int i = 0; i < 8; i++) eng_w[16*i +: 16] = r_w[i];
  end

  assign eng_h       = r_h;
  assign res_valid   = (r_cnt != '0);
  assign res_pred    = res_valid & r_fp[r_rp];
  assign res_margin  = res_valid ? r_fm[r_rp] : 16'h0000;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_to_err;
  assign cfg_err     = r_cfg_err;
  assign sample_cnt  = r_scnt;

endmodule
